// File: rtl/alu_pipe.sv
// alu_pipe: pipelined 8-op ALU with status flags, tag pass-through and
// valid/ready handshaking on both sides. Stages collapse bubbles, so up
// to LATENCY operations can be held while the consumer stalls.
// WIDTH must be a power of two >= 2; LATENCY is legal in 1..4.

// One pipeline register: a valid bit plus an opaque payload vector.
module alu_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          vld_in,
    input  logic [PW-1:0] data_in,
    output logic          vld,
    output logic [PW-1:0] data
);

    // Load on demand, otherwise hold; reset drops the op and zeroes payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= vld_in;
            data <= data_in;
        end
    end

endmodule

module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SH_W = $clog2(WIDTH);

    // Codes 0..3 keep the legacy 4-op ALU encoding.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_NOT = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
    } payload_t;

    localparam int PW = $bits(payload_t);

    logic [SH_W-1:0] sh;
    logic [WIDTH:0]  add_ext;
    logic [WIDTH:0]  sub_ext;
    logic [WIDTH:0]  shl_ext;
    logic [WIDTH:0]  shr_ext;
    payload_t        calc;

    assign sh = b[SH_W-1:0];

    // Datapath: every op's result and flags are computed from the inputs and
    // captured straight into stage 0. Shifts use a one-bit extension so the
    // last bit shifted out lands in the spare bit (and is 0 when sh == 0).
    always_comb begin
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << sh;
        shr_ext = {a, 1'b0} >> sh;
        calc     = '0;
        calc.tag = in_tag;
        case (op_e'(op))
            OP_ADD: begin
                calc.result = add_ext[WIDTH-1:0];
                calc.c      = add_ext[WIDTH];
                calc.v      = (a[WIDTH-1] == b[WIDTH-1]) &&
                              (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                calc.result = sub_ext[WIDTH-1:0];
                calc.c      = sub_ext[WIDTH];   // borrow: a < b unsigned
                calc.v      = (a[WIDTH-1] != b[WIDTH-1]) &&
                              (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: calc.result = a & b;
            OP_NOT: calc.result = ~b;
            OP_OR:  calc.result = a | b;
            OP_XOR: calc.result = a ^ b;
            OP_SHL: begin
                calc.result = shl_ext[WIDTH-1:0];
                calc.c      = shl_ext[WIDTH];
            end
            OP_SHR: begin
                calc.result = shr_ext[WIDTH:1];
                calc.c      = shr_ext[0];
            end
        endcase
        calc.z = (calc.result == '0);
        calc.n = calc.result[WIDTH-1];
    end

    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] load;
    logic [PW-1:0]      stage_data [LATENCY];

    // Bubble-collapsing advance: a stage loads if it is empty or the stage
    // after it is moving; the last stage moves when the consumer accepts.
    always_comb begin
        load = '0;
        load[LATENCY-1] = !vld_pipe[LATENCY-1] || out_ready;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            load[k] = !vld_pipe[k] || load[k+1];
        end
    end

    // Nothing is accepted while reset is asserted.
    assign in_ready = load[0] && !rst;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_first
            alu_pipe_stage #(.PW(PW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load    (load[k]),
                .vld_in  (in_valid),
                .data_in (calc),
                .vld     (vld_pipe[k]),
                .data    (stage_data[k])
            );
        end else begin : g_next
            alu_pipe_stage #(.PW(PW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .load    (load[k]),
                .vld_in  (vld_pipe[k-1]),
                .data_in (stage_data[k-1]),
                .vld     (vld_pipe[k]),
                .data    (stage_data[k])
            );
        end
    end

    payload_t out_p;
    assign out_p     = payload_t'(stage_data[LATENCY-1]);
    assign out_valid = vld_pipe[LATENCY-1];
    assign result    = out_p.result;
    assign out_tag   = out_p.tag;
    assign flag_z    = out_p.z;
    assign flag_n    = out_p.n;
    assign flag_c    = out_p.c;
    assign flag_v    = out_p.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32, LATENCY=2) plus a random sweep
// of LATENCY=1 and LATENCY=4 instances against a reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic        flag_z, flag_n, flag_c, flag_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .LATENCY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v)
    );

    // Random-sweep instances: index 0 is LATENCY=1, index 1 is LATENCY=4.
    logic        rv [2];
    logic        ri [2];
    logic [2:0]  rop [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [3:0]  rtag [2];
    logic        rov [2];
    logic        ror [2];
    logic [31:0] rres [2];
    logic [3:0]  rotag [2];
    logic        rz [2], rn [2], rc [2], rvf [2];

    alu_pipe #(.WIDTH(32), .LATENCY(1), .TAG_W(4)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(rv[0]), .in_ready(ri[0]),
        .op(rop[0]), .a(ra[0]), .b(rb[0]), .in_tag(rtag[0]),
        .out_valid(rov[0]), .out_ready(ror[0]), .result(rres[0]),
        .out_tag(rotag[0]), .flag_z(rz[0]), .flag_n(rn[0]),
        .flag_c(rc[0]), .flag_v(rvf[0])
    );

    alu_pipe #(.WIDTH(32), .LATENCY(4), .TAG_W(4)) dut_l4 (
        .clk(clk), .rst(rst), .in_valid(rv[1]), .in_ready(ri[1]),
        .op(rop[1]), .a(ra[1]), .b(rb[1]), .in_tag(rtag[1]),
        .out_valid(rov[1]), .out_ready(ror[1]), .result(rres[1]),
        .out_tag(rotag[1]), .flag_z(rz[1]), .flag_n(rn[1]),
        .flag_c(rc[1]), .flag_v(rvf[1])
    );

    // Reference model, packed as {result, tag, z, n, c, v}.
    function automatic logic [39:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb, input logic [3:0] mtag);
        logic [31:0] r;
        logic [32:0] t;
        logic        c, v;
        int          s;
        c = 1'b0; v = 1'b0; r = '0;
        s = int'(mb[4:0]);
        case (mop)
            3'd0: begin
                t = {1'b0, ma} + {1'b0, mb};
                r = t[31:0]; c = t[32];
                v = (ma[31] == mb[31]) && (r[31] != ma[31]);
            end
            3'd1: begin
                r = ma - mb; c = (ma < mb);
                v = (ma[31] != mb[31]) && (r[31] != ma[31]);
            end
            3'd2: r = ma & mb;
            3'd3: r = ~mb;
            3'd4: r = ma | mb;
            3'd5: r = ma ^ mb;
            3'd6: begin r = ma << s; if (s != 0) c = ma[32-s]; end
            default: begin r = ma >> s; if (s != 0) c = ma[s-1]; end
        endcase
        return {r, mtag, (r == 32'd0), r[31], c, v};
    endfunction

    // Present one op, hold for one edge (caller guarantees in_ready).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] t);
        op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; ror[i] = 1'b1; end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({result, out_tag, flag_z, flag_n, flag_c, flag_v} !== 40'd0) begin
            errors++; $display("FAIL reset_payload got %h/%h exp 0", result, out_tag); end
        checks++; if (rov[0] !== 1'b0 || rov[1] !== 1'b0) begin
            errors++; $display("FAIL reset_rand_valid got %b%b exp 00", rov[0], rov[1]); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(3'd0, 32'hFFFF_FFFF, 32'd1, 4'd5);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL add_result got %h exp 0", result); end
        checks++; if ({flag_z, flag_n, flag_c, flag_v} !== 4'b1010) begin
            errors++; $display("FAIL add_flags got %b exp 1010", {flag_z, flag_n, flag_c, flag_v}); end
        checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL add_tag got %0d exp 5", out_tag); end
        drain();
    endtask

    task automatic test_sub();
        issue(3'd1, 32'h8000_0000, 32'd1, 4'd1);
        issue(3'd1, 32'd3, 32'd5, 4'd2);
        // first SUB is now at the output, second one right behind it
        checks++; if (result !== 32'h7FFF_FFFF || out_tag !== 4'd1) begin
            errors++; $display("FAIL sub_ovf_result got %h/%0d exp 7fffffff/1", result, out_tag); end
        checks++; if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0001) begin
            errors++; $display("FAIL sub_ovf_flags got %b exp 0001", {flag_z, flag_n, flag_c, flag_v}); end
        @(posedge clk); #1;
        checks++; if (result !== 32'hFFFF_FFFE || out_tag !== 4'd2) begin
            errors++; $display("FAIL sub_borrow_result got %h/%0d exp fffffffe/2", result, out_tag); end
        checks++; if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0110) begin
            errors++; $display("FAIL sub_borrow_flags got %b exp 0110", {flag_z, flag_n, flag_c, flag_v}); end
        drain();
    endtask

    task automatic test_logic_shift();
        issue(3'd6, 32'h8000_0001, 32'h21, 4'd3);
        issue(3'd7, 32'd1, 32'd0, 4'd4);
        checks++; if (result !== 32'h2 || flag_c !== 1'b1) begin
            errors++; $display("FAIL shl got %h c=%b exp 2 c=1", result, flag_c); end
        issue(3'd3, 32'h1234_5678, 32'h0F0F_0F0F, 4'd6);
        checks++; if (result !== 32'h1 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++; $display("FAIL shr0 got %h c=%b exp 1 c=0", result, flag_c); end
        issue(3'd5, 32'hFF00_FF00, 32'hF0F0_F0F0, 4'd7);
        checks++; if (result !== 32'hF0F0_F0F0 || flag_n !== 1'b1) begin
            errors++; $display("FAIL not got %h n=%b exp f0f0f0f0 n=1", result, flag_n); end
        issue(3'd7, 32'h8000_0000, 32'h1F, 4'd8);
        checks++; if (result !== 32'h0FF0_0FF0) begin errors++; $display("FAIL xor got %h exp 0ff00ff0", result); end
        @(posedge clk); #1;
        checks++; if (result !== 32'h1 || flag_c !== 1'b0) begin
            errors++; $display("FAIL shr31 got %h c=%b exp 1 c=0", result, flag_c); end
        drain();
    endtask

    task automatic test_back_to_back();
        int nt, ne, cyc;
        logic hold;
        logic [31:0] hold_res;
        logic [3:0] hold_tag;
        logic exp_rdy;
        nt = 0; ne = 0; hold = 1'b0; hold_res = '0; hold_tag = '0;
        for (cyc = 0; cyc < 40 && ne < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 7);
            in_valid = (nt < 6);
            op = 3'd0; a = 32'(nt); b = 32'd100; in_tag = 4'(nt);
            #1;
            exp_rdy = ((nt - ne) < 2) || out_ready;
            checks++; if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_in_ready cyc %0d got %b exp %b", cyc, in_ready, exp_rdy); end
            if (hold) begin
                checks++; if (out_valid !== 1'b1 || result !== hold_res || out_tag !== hold_tag) begin
                    errors++; $display("FAIL bp_stable cyc %0d got %h/%0d exp %h/%0d", cyc, result, out_tag, hold_res, hold_tag); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_tag !== 4'(ne) || result !== 32'(ne + 100)) begin
                    errors++; $display("FAIL bp_order got %h/%0d exp %h/%0d", result, out_tag, ne + 100, ne); end
                ne++;
            end
            hold = out_valid && !out_ready; hold_res = result; hold_tag = out_tag;
            if (in_valid && in_ready) nt++;
            @(posedge clk); #1;
        end
        checks++; if (ne !== 6 || nt !== 6) begin
            errors++; $display("FAIL bp_count got %0d out %0d in exp 6", ne, nt); end
        drain();
    endtask

    task automatic test_bubble();
        int nt;
        nt = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (cyc % 2 == 0);
            op = 3'd4; a = 32'h10; b = 32'(nt); in_tag = 4'(10 + nt);
            #1;
            checks++; if (in_ready !== (nt < 2)) begin
                errors++; $display("FAIL bubble_in_ready cyc %0d got %b exp %b", cyc, in_ready, nt < 2); end
            if (in_valid && in_ready) nt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd10 || result !== 32'h10) begin
            errors++; $display("FAIL bubble_first got %b/%0d/%h exp 1/10/10", out_valid, out_tag, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd11 || result !== 32'h11) begin
            errors++; $display("FAIL bubble_second got %b/%0d/%h exp 1/11/11", out_valid, out_tag, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got %b exp 0", out_valid); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        issue(3'd0, 32'd1, 32'd1, 4'd1);
        issue(3'd0, 32'd2, 32'd2, 4'd2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", out_valid); end
        issue(3'd0, 32'd7, 32'd2, 4'd9);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %b exp 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_tag !== 4'd9 || result !== 32'd9) begin
            errors++; $display("FAIL rst_new_op got %b/%0d/%h exp 1/9/9", out_valid, out_tag, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_alone got %b exp 0", out_valid); end
        drain();
    endtask

    task automatic test_random();
        logic [39:0] exp_mem [2][0:1023];
        int wr [2];
        int rd [2];
        logic [39:0] got;
        for (int i = 0; i < 2; i++) begin wr[i] = 0; rd[i] = 0; end
        for (int cyc = 0; cyc < 420; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc < 400) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ror[i] = ($urandom_range(0, 3) != 0);
                end else begin
                    rv[i] = 1'b0; ror[i] = 1'b1;
                end
                rop[i] = 3'($urandom_range(0, 7));
                rtag[i] = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0: ra[i] = 32'hFFFF_FFFF;
                    1: ra[i] = 32'h8000_0000 | 32'($urandom_range(0, 3));
                    default: ra[i] = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0: rb[i] = 32'($urandom_range(0, 2));
                    1: rb[i] = 32'h7FFF_FFFF;
                    default: rb[i] = $urandom;
                endcase
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rov[i] && ror[i]) begin
                    got = {rres[i], rotag[i], rz[i], rn[i], rc[i], rvf[i]};
                    checks++;
                    if (rd[i] >= wr[i]) begin
                        errors++; $display("FAIL rand%0d_spurious got %h exp none", i, got);
                    end else begin
                        if (got !== exp_mem[i][rd[i]]) begin
                            errors++; $display("FAIL rand%0d_op%0d got %h exp %h", i, rd[i], got, exp_mem[i][rd[i]]);
                        end
                        rd[i]++;
                    end
                end
                if (rv[i] && ri[i]) begin
                    exp_mem[i][wr[i]] = model(rop[i], ra[i], rb[i], rtag[i]);
                    wr[i]++;
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (rd[i] !== wr[i] || wr[i] < 100) begin
                errors++; $display("FAIL rand%0d_count got %0d out exp %0d", i, rd[i], wr[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ror[i] = 1'b1; rop[i] = '0; ra[i] = '0; rb[i] = '0; rtag[i] = '0;
        end
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_back_to_back();
        test_bubble();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
